// File: rtl/imm_encoder_if.sv
// Request/response stream bundle between the instruction generator and imm_encoder.
// The master side is the requester; the slave side is the encoder.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface imm_encoder_if;
  logic                   in_valid;
  logic                   in_ready;
  logic [`DATA_WIDTH-1:0] in_tmpl;
  logic [`DATA_WIDTH-1:0] in_imm;
  logic [2:0]             in_imm_src;

  logic                   out_valid;
  logic                   out_ready;
  logic [`DATA_WIDTH-1:0] out_instr;
  logic                   out_err;
  logic                   out_last;

  modport master (
    output in_valid, in_tmpl, in_imm, in_imm_src, out_ready,
    input  in_ready, out_valid, out_instr, out_err, out_last
  );

  modport slave (
    input  in_valid, in_tmpl, in_imm, in_imm_src, out_ready,
    output in_ready, out_valid, out_instr, out_err, out_last
  );
endinterface

// File: rtl/imm_encoder.sv
// Packs a 32-bit immediate into RV32I I/S/B/J/U fields and expands load-immediate
// requests into ADDI, LUI or LUI+ADDI, behind one registered valid/ready output stage.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module imm_encoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  imm_encoder_if.slave         bus,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int DW = `DATA_WIDTH;

  localparam logic [2:0] SRC_I  = 3'b000;
  localparam logic [2:0] SRC_S  = 3'b001;
  localparam logic [2:0] SRC_B  = 3'b010;
  localparam logic [2:0] SRC_J  = 3'b011;
  localparam logic [2:0] SRC_U  = 3'b100;
  localparam logic [2:0] SRC_LI = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    HOLD_FIRST,
    HOLD_LAST
  } state_e;

  state_e                 state_q, state_d;
  logic [DW-1:0]          instr_q, instr_d;
  logic [DW-1:0]          addi_q,  addi_d;
  logic                   err_q,   err_d;
  logic                   last_q,  last_d;
  logic [ERR_CNT_W-1:0]   cnt_q,   cnt_d;

  logic [DW-1:0] imm;
  logic [DW-1:0] tmpl;
  logic [4:0]    rd;
  logic [11:0]   lo;
  logic [19:0]   hi;
  logic          fits12, fits13, fits21;

  logic [DW-1:0] enc_instr;
  logic [DW-1:0] enc_addi;
  logic          enc_err;
  logic          enc_two;

  logic          in_ready_w;
  logic          accept;

  assign imm  = bus.in_imm;
  assign tmpl = bus.in_tmpl;
  assign rd   = tmpl[11:7];
  assign lo   = imm[11:0];
  // Upper part is pre-compensated for the sign extension ADDI applies to lo.
  assign hi   = imm[31:12] + {19'd0, imm[11]};

  assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    enc_instr = tmpl;
    enc_addi  = '0;
    enc_err   = 1'b0;
    enc_two   = 1'b0;
    case (bus.in_imm_src)
      SRC_I: begin
        enc_instr[31:20] = imm[11:0];
        enc_err          = ~fits12;
      end
      SRC_S: begin
        enc_instr[31:25] = imm[11:5];
        enc_instr[11:7]  = imm[4:0];
        enc_err          = ~fits12;
      end
      SRC_B: begin
        enc_instr[31]    = imm[12];
        enc_instr[30:25] = imm[10:5];
        enc_instr[11:8]  = imm[4:1];
        enc_instr[7]     = imm[11];
        enc_err          = ~fits13 | imm[0];
      end
      SRC_J: begin
        enc_instr[31]    = imm[20];
        enc_instr[30:21] = imm[10:1];
        enc_instr[20]    = imm[11];
        enc_instr[19:12] = imm[19:12];
        enc_err          = ~fits21 | imm[0];
      end
      SRC_U: begin
        enc_instr[31:12] = imm[31:12];
        enc_err          = |imm[11:0];
      end
      SRC_LI: begin
        if (fits12) begin
          enc_instr = {lo, 5'd0, 3'b000, rd, 7'h13};
        end else begin
          enc_instr = {hi, rd, 7'h37};
          if (lo != 12'd0) begin
            enc_two  = 1'b1;
            enc_addi = {lo, rd, 3'b000, rd, 7'h13};
          end
        end
      end
      default: enc_err = 1'b1;
    endcase
  end

  assign in_ready_w = (state_q == IDLE) | ((state_q == HOLD_LAST) & bus.out_ready);
  assign accept     = bus.in_valid & in_ready_w;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    addi_d  = addi_q;
    err_d   = err_q;
    last_d  = last_q;
    cnt_d   = cnt_q;

    case (state_q)
      HOLD_FIRST: begin
        if (bus.out_ready) begin
          instr_d = addi_q;
          err_d   = 1'b0;
          last_d  = 1'b1;
          state_d = HOLD_LAST;
        end
      end
      HOLD_LAST: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: ;
    endcase

    // A new request overrides the drain-to-IDLE decision above (back-to-back streaming).
    if (accept) begin
      instr_d = enc_instr;
      addi_d  = enc_addi;
      err_d   = enc_err;
      last_d  = ~enc_two;
      state_d = enc_two ? HOLD_FIRST : HOLD_LAST;
      if (enc_err && (cnt_q != {ERR_CNT_W{1'b1}})) cnt_d = cnt_q + ERR_CNT_W'(1);
    end
  end

  // NOTE: the output data registers are reset too, because their reset value is visible on the ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      instr_q <= '0;
      addi_q  <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      instr_q <= instr_d;
      addi_q  <= addi_d;
      err_q   <= err_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = (state_q != IDLE);
  assign bus.out_instr = instr_q;
  assign bus.out_err   = err_q;
  assign bus.out_last  = last_q;
  assign err_cnt       = cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: a table of single-beat encodings plus hand-written
// sequences for two-beat LI, backpressure, streaming, reset mid-request and counter saturation.
module tb_imm_encoder;

  localparam logic [2:0] SRC_I  = 3'b000;
  localparam logic [2:0] SRC_S  = 3'b001;
  localparam logic [2:0] SRC_B  = 3'b010;
  localparam logic [2:0] SRC_J  = 3'b011;
  localparam logic [2:0] SRC_U  = 3'b100;
  localparam logic [2:0] SRC_LI = 3'b101;

  typedef struct {
    logic [31:0] tmpl;
    logic [31:0] imm;
    logic [2:0]  src;
    logic [31:0] instr;
    logic        err;
    logic [7:0]  cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] err_cnt;
  int         checks   = 0;
  int         failures = 0;
  vec_t       vecs[$];

  imm_encoder_if bus();

  imm_encoder #(.ERR_CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] t, input logic [31:0] im,
                       input logic [2:0] s);
    bus.in_valid   = v;
    bus.in_tmpl    = t;
    bus.in_imm     = im;
    bus.in_imm_src = s;
  endtask

  task automatic check_beat(input string tag, input logic [31:0] instr, input logic err,
                            input logic last);
    check({tag, " valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, " instr"}, bus.out_instr, instr);
    check({tag, " err"},   {31'd0, bus.out_err},  {31'd0, err});
    check({tag, " last"},  {31'd0, bus.out_last}, {31'd0, last});
  endtask

  initial begin
    // tmpl, imm, src, expected instr, expected err, expected cumulative err_cnt
    vecs.push_back('{32'h00000013, 32'hFFFFFFFF, SRC_I,  32'hFFF00013, 1'b0, 8'd0});
    vecs.push_back('{32'h00000013, 32'h000007FF, SRC_I,  32'h7FF00013, 1'b0, 8'd0});
    vecs.push_back('{32'h00000013, 32'h00000800, SRC_I,  32'h80000013, 1'b1, 8'd1});
    vecs.push_back('{32'hFFF00013, 32'h00000005, SRC_I,  32'h00500013, 1'b0, 8'd1});
    vecs.push_back('{32'h00002023, 32'hFFFFFFFC, SRC_S,  32'hFE002E23, 1'b0, 8'd1});
    vecs.push_back('{32'h00002023, 32'hFFFFF7FF, SRC_S,  32'h7E002FA3, 1'b1, 8'd2});
    vecs.push_back('{32'h00000063, 32'h00000800, SRC_B,  32'h000000E3, 1'b0, 8'd2});
    vecs.push_back('{32'h00000063, 32'h00001001, SRC_B,  32'h80000063, 1'b1, 8'd3});
    vecs.push_back('{32'h00000063, 32'hFFFFF000, SRC_B,  32'h80000063, 1'b0, 8'd3});
    vecs.push_back('{32'h00000063, 32'h00001000, SRC_B,  32'h80000063, 1'b1, 8'd4});
    vecs.push_back('{32'h00000063, 32'h00000005, SRC_B,  32'h00000263, 1'b1, 8'd5});
    vecs.push_back('{32'h00000063, 32'h00000FFE, SRC_B,  32'h7E000FE3, 1'b0, 8'd5});
    vecs.push_back('{32'h0000006F, 32'hFFFFF000, SRC_J,  32'h800FF06F, 1'b0, 8'd5});
    vecs.push_back('{32'h0000006F, 32'h00100000, SRC_J,  32'h8000006F, 1'b1, 8'd6});
    vecs.push_back('{32'h0000006F, 32'h00000800, SRC_J,  32'h0010006F, 1'b0, 8'd6});
    vecs.push_back('{32'h00000037, 32'h12345000, SRC_U,  32'h12345037, 1'b0, 8'd6});
    vecs.push_back('{32'h00000037, 32'h12345001, SRC_U,  32'h12345037, 1'b1, 8'd7});
    vecs.push_back('{32'hDEADBEEF, 32'h00000000, 3'b110, 32'hDEADBEEF, 1'b1, 8'd8});
    vecs.push_back('{32'h00000013, 32'h00000005, 3'b111, 32'h00000013, 1'b1, 8'd9});
    vecs.push_back('{32'hFFFFF1FF, 32'hFFFFFFFF, SRC_LI, 32'hFFF00193, 1'b0, 8'd9});
    vecs.push_back('{32'h00000080, 32'h00001000, SRC_LI, 32'h000010B7, 1'b0, 8'd9});
    vecs.push_back('{32'h00000080, 32'h80000000, SRC_LI, 32'h800000B7, 1'b0, 8'd9});
    vecs.push_back('{32'h00000080, 32'h000007FF, SRC_LI, 32'h7FF00093, 1'b0, 8'd9});
    vecs.push_back('{32'h00000080, 32'hFFFFF800, SRC_LI, 32'h80000093, 1'b0, 8'd9});

    rst = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 3'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset valid",   {31'd0, bus.out_valid}, 32'd0);
    check("reset instr",   bus.out_instr, 32'd0);
    check("reset err",     {31'd0, bus.out_err},  32'd0);
    check("reset last",    {31'd0, bus.out_last}, 32'd0);
    check("reset err_cnt", {24'd0, err_cnt}, 32'd0);
    check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Single-beat table: one request, then one idle cycle to drain.
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].tmpl, vecs[i].imm, vecs[i].src);
      @(negedge clk);
      drive(1'b0, 32'd0, 32'd0, 3'd0);
      check_beat($sformatf("vec%0d", i), vecs[i].instr, vecs[i].err, 1'b1);
      check($sformatf("vec%0d err_cnt", i), {24'd0, err_cnt}, {24'd0, vecs[i].cnt});
      @(negedge clk);
      check($sformatf("vec%0d drained", i), {31'd0, bus.out_valid}, 32'd0);
    end

    // Two-beat LI under 5 cycles of backpressure on the LUI beat.
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h00000280, 32'h12345678, SRC_LI);
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0, 3'd0);
    check_beat("li5 lui", 32'h123452B7, 1'b0, 1'b0);
    check("li5 in_ready", {31'd0, bus.in_ready}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_beat($sformatf("li5 hold%0d", k), 32'h123452B7, 1'b0, 1'b0);
      check($sformatf("li5 hold%0d in_ready", k), {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_beat("li5 addi", 32'h67828293, 1'b0, 1'b1);
    check("li5 addi in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    check("li5 drained", {31'd0, bus.out_valid}, 32'd0);
    check("li5 err_cnt", {24'd0, err_cnt}, 32'd9);

    // Two-beat LI where hi needs the +1 carry; stall the final beat once.
    drive(1'b1, 32'h00000080, 32'h7FFFF800, SRC_LI);
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0, 3'd0);
    check_beat("li1 lui", 32'h800000B7, 1'b0, 1'b0);
    @(negedge clk);
    check_beat("li1 addi", 32'h80008093, 1'b0, 1'b1);
    bus.out_ready = 1'b0;
    #1;
    check("li1 stall in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    check_beat("li1 addi held", 32'h80008093, 1'b0, 1'b1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("li1 drained", {31'd0, bus.out_valid}, 32'd0);

    // Four I-type requests streamed back to back: one beat per cycle.
    drive(1'b1, 32'h00000013, 32'd1, SRC_I);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_beat($sformatf("stream%0d", k), 32'h00000013 | (k << 20), 1'b0, 1'b1);
      check($sformatf("stream%0d in_ready", k), {31'd0, bus.in_ready}, 32'd1);
      if (k < 4) drive(1'b1, 32'h00000013, k + 1, SRC_I);
      else       drive(1'b0, 32'd0, 32'd0, 3'd0);
    end
    @(negedge clk);
    check("stream drained", {31'd0, bus.out_valid}, 32'd0);

    // Reset while the LUI beat is shown: the pending ADDI must never appear.
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h00000280, 32'h12345678, SRC_LI);
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0, 3'd0);
    check_beat("rst_mid lui", 32'h123452B7, 1'b0, 1'b0);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_mid instr", bus.out_instr, 32'd0);
    check("rst_mid err_cnt", {24'd0, err_cnt}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("rst_mid no addi", {31'd0, bus.out_valid}, 32'd0);
    end

    // Error counter saturates at 255 and does not wrap.
    drive(1'b1, 32'h00000013, 32'd0, 3'b110);
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 254) check("sat 254", {24'd0, err_cnt}, 32'd254);
      if (k == 255) check("sat 255", {24'd0, err_cnt}, 32'd255);
    end
    drive(1'b0, 32'd0, 32'd0, 3'd0);
    check("sat hold", {24'd0, err_cnt}, 32'd255);
    check("sat err", {31'd0, bus.out_err}, 32'd1);
    @(negedge clk);
    check("sat drained", {31'd0, bus.out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
